// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [1:0]       gnt_id;
    logic             timeout;

    modport master (output req, input gnt, gnt_valid, gnt_id, timeout);
    modport slave  (input req, output gnt, gnt_valid, gnt_id, timeout);
endinterface

// File: rtl/encoder4x2.sv
// Lab one-hot to binary encoder; an all-zero input encodes to 0.
module encoder4x2 (
    input  logic [3:0] onehot,
    output logic [1:0] idx
);
    always_comb begin
        idx = '0;
        case (onehot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that forces rotation under contention.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter int unsigned CNT_W    = 4
) (
    input logic            clk,
    input logic            nrst,
    rr_arbiter4_if.slave   bus
);
    // With no limit the counter simply saturates at all-ones and never times out.
    localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [2:0]       pick;
    logic [N_REQ-1:0] win_oh;
    logic             owner_req;
    logic             others_req;
    logic [1:0]       gnt_id;

    // Returns {found, index} of the first requester at or after p.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [2:0] res;
        res = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = p + 2'(k);
            if (!res[2] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        pick       = rr_pick(bus.req, ptr_q);
        win_oh     = 4'b0001 << pick[1:0];
        owner_req  = |(bus.req & gnt_q);
        others_req = |(bus.req & ~gnt_q);

        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    gnt_d      = win_oh;
                    ptr_d      = pick[1:0] + 2'd1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Owner's req is already low, so the pick cannot return it.
                    if (pick[2]) begin
                        gnt_d      = win_oh;
                        ptr_d      = pick[1:0] + 2'd1;
                        hold_cnt_d = '0;
                    end else begin
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) && others_req) begin
                    // ptr already sits at owner+1, so the owner is searched last.
                    gnt_d      = win_oh;
                    ptr_d      = pick[1:0] + 2'd1;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    encoder4x2 u_enc (
        .onehot (gnt_q),
        .idx    (gnt_id)
    );

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4 with MAX_HOLD=8.
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] gnt;
        logic       to;
    } exp_t;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    exp_t sb[$];

    rr_arbiter4_if u_if ();

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 4'd1;
            4'b0100: return 4'd2;
            4'b1000: return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".gnt"},       u_if.gnt,                e.gnt);
        chk({tag, ".gnt_valid"}, {3'b000, u_if.gnt_valid}, {3'b000, |e.gnt});
        chk({tag, ".gnt_id"},    {2'b00, u_if.gnt_id},     id_of(e.gnt));
        chk({tag, ".timeout"},   {3'b000, u_if.timeout},   {3'b000, e.to});
    endtask

    // Called in the low phase: drive req, expect the given result after the next rising edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic eto);
        exp_t e;
        u_if.req = r;
        sb.push_back('{gnt: eg, to: eto});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_outputs(tag, e);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nrst     = 1'b0;
        u_if.req = 4'b1111;

        // 1: reset holds outputs low despite full request
        repeat (3) @(negedge clk);
        chk_outputs("reset", '{gnt: 4'b0000, to: 1'b0});
        nrst = 1'b1;
        step("rst_first", 4'b1111, 4'b0001, 1'b0);
        step("rst_rel",   4'b0000, 4'b0000, 1'b0);
        step("rst_idle",  4'b0000, 4'b0000, 1'b0);

        // 2: single requester, 3-cycle hold then release to idle
        for (int i = 0; i < 3; i++) step("single", 4'b0100, 4'b0100, 1'b0);
        step("single_rel",  4'b0000, 4'b0000, 1'b0);
        step("single_idle", 4'b0000, 4'b0000, 1'b0);

        // 3: rotation by release with no idle bubble
        pulse_reset();
        step("rot0a", 4'b1111, 4'b0001, 1'b0);
        step("rot0b", 4'b1111, 4'b0001, 1'b0);
        step("rot1a", 4'b1110, 4'b0010, 1'b0);
        step("rot1b", 4'b1110, 4'b0010, 1'b0);
        step("rot2a", 4'b1100, 4'b0100, 1'b0);
        step("rot2b", 4'b1100, 4'b0100, 1'b0);
        step("rot3a", 4'b1000, 4'b1000, 1'b0);
        step("rot3b", 4'b1000, 4'b1000, 1'b0);
        step("rot0c", 4'b0001, 4'b0001, 1'b0);
        step("rot_end", 4'b0000, 4'b0000, 1'b0);

        // 4: timeout forces alternation every 8 cycles
        pulse_reset();
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int c = 0; c < 8; c++)
                step("tmo", 4'b0011, (rnd % 2 == 0) ? 4'b0001 : 4'b0010, (rnd != 0) && (c == 0));
        end
        step("tmo_end", 4'b0000, 4'b0000, 1'b0);

        // 5: sole requester keeps grant past the limit, then a newcomer triggers immediate timeout
        for (int c = 0; c < 20; c++) step("sole", 4'b1000, 4'b1000, 1'b0);
        step("sole_join", 4'b1001, 4'b0001, 1'b1);
        step("sole_end",  4'b0000, 4'b0000, 1'b0);

        // 6: asynchronous reset mid-grant
        step("ar_grant", 4'b0100, 4'b0100, 1'b0);
        nrst = 1'b0;
        #1;
        chk_outputs("ar_async", '{gnt: 4'b0000, to: 1'b0});
        u_if.req = 4'b0110;
        #1;
        nrst = 1'b1;
        step("ar_after",  4'b0110, 4'b0010, 1'b0);
        step("ar_hold",   4'b0110, 4'b0010, 1'b0);
        step("ar_rel",    4'b0100, 4'b0100, 1'b0);
        step("ar_end",    4'b0000, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
